// File: rtl/hilo_ctrl.sv
// hilo_ctrl: HI/LO write sequencer for the EX stage.
// Single-cycle MTHI/MTLO/MULT/MULTU, 32-step restoring divider for DIV/DIVU
// with pipeline stall while dividing and flush-based cancellation.
module hilo_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i,
   input  logic [2:0]  op_i,
   input  logic [31:0] rs_i,
   input  logic [31:0] rt_i,
   input  logic        annul_i,
   input  logic [31:0] hi_i,
   input  logic [31:0] lo_i,
   output logic        we_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        stall_o
);

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_MTHI  = 3'd1,
      OP_MTLO  = 3'd2,
      OP_MULT  = 3'd3,
      OP_MULTU = 3'd4,
      OP_DIV   = 3'd5,
      OP_DIVU  = 3'd6,
      OP_RSVD  = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   op_e         op;
   state_e      state, state_n;
   logic [4:0]  cnt, cnt_n;
   logic [31:0] dvd, dvd_n;     // dividend, shifted left one bit per step
   logic [31:0] dvs, dvs_n;     // divisor magnitude
   logic [31:0] rem, rem_n;     // partial remainder (always < divisor)
   logic [31:0] quo, quo_n;     // quotient bits, MSB first
   logic        qneg, qneg_n;
   logic        rneg, rneg_n;
   logic        we_n;
   logic [31:0] hi_n, lo_n;

   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;
   logic [31:0]        rs_abs, rt_abs;
   logic [32:0]        shifted, diff;
   logic [31:0]        rem_step, quo_step, q_fix, r_fix;

   assign op = op_e'(op_i);

   assign prod_s = $signed({{32{rs_i[31]}}, rs_i}) * $signed({{32{rt_i[31]}}, rt_i});
   assign prod_u = {32'd0, rs_i} * {32'd0, rt_i};

   assign rs_abs = rs_i[31] ? (~rs_i + 32'd1) : rs_i;
   assign rt_abs = rt_i[31] ? (~rt_i + 32'd1) : rt_i;

   // One restoring step: the borrow out of the 33-bit subtract decides the quotient bit.
   assign shifted  = {rem, dvd[31]};
   assign diff     = shifted - {1'b0, dvs};
   assign rem_step = diff[32] ? shifted[31:0] : diff[31:0];
   assign quo_step = {quo[30:0], ~diff[32]};
   assign q_fix    = qneg ? (~quo_step + 32'd1) : quo_step;
   assign r_fix    = rneg ? (~rem_step + 32'd1) : rem_step;

   // Next-state, datapath updates and the combinational stall request.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      dvd_n   = dvd;
      dvs_n   = dvs;
      rem_n   = rem;
      quo_n   = quo;
      qneg_n  = qneg;
      rneg_n  = rneg;
      we_n    = 1'b0;
      hi_n    = hi_o;
      lo_n    = lo_o;
      stall_o = 1'b0;
      case (state)
         S_IDLE: begin
            if (valid_i && !annul_i) begin
               case (op)
                  OP_MTHI: begin
                     we_n = 1'b1;
                     hi_n = rs_i;
                     lo_n = lo_i;
                  end
                  OP_MTLO: begin
                     we_n = 1'b1;
                     hi_n = hi_i;
                     lo_n = rs_i;
                  end
                  OP_MULT: begin
                     we_n = 1'b1;
                     hi_n = prod_s[63:32];
                     lo_n = prod_s[31:0];
                  end
                  OP_MULTU: begin
                     we_n = 1'b1;
                     hi_n = prod_u[63:32];
                     lo_n = prod_u[31:0];
                  end
                  OP_DIV, OP_DIVU: begin
                     stall_o = 1'b1;
                     dvd_n   = (op == OP_DIV) ? rs_abs : rs_i;
                     dvs_n   = (op == OP_DIV) ? rt_abs : rt_i;
                     qneg_n  = (op == OP_DIV) && (rs_i[31] ^ rt_i[31]);
                     rneg_n  = (op == OP_DIV) && rs_i[31];
                     rem_n   = '0;
                     quo_n   = '0;
                     cnt_n   = '0;
                     if (rt_i == 32'd0) begin
                        // Divide by zero skips RUN and writes the raw result directly.
                        state_n = S_DONE;
                        we_n    = 1'b1;
                        hi_n    = rs_i;
                        lo_n    = '1;
                     end else begin
                        state_n = S_RUN;
                     end
                  end
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            if (annul_i) begin
               state_n = S_IDLE;
            end else begin
               stall_o = 1'b1;
               rem_n   = rem_step;
               quo_n   = quo_step;
               dvd_n   = {dvd[30:0], 1'b0};
               cnt_n   = cnt + 5'd1;
               if (cnt == 5'd31) begin
                  state_n = S_DONE;
                  we_n    = 1'b1;
                  hi_n    = r_fix;
                  lo_n    = q_fix;
               end
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         dvd   <= '0;
         dvs   <= '0;
         rem   <= '0;
         quo   <= '0;
         qneg  <= 1'b0;
         rneg  <= 1'b0;
         we_o  <= 1'b0;
         hi_o  <= '0;
         lo_o  <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         dvd   <= dvd_n;
         dvs   <= dvs_n;
         rem   <= rem_n;
         quo   <= quo_n;
         qneg  <= qneg_n;
         rneg  <= rneg_n;
         we_o  <= we_n;
         hi_o  <= hi_n;
         lo_o  <= lo_n;
      end
   end

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: directed + randomized bench for hilo_ctrl against a
// cycle-scheduled arithmetic reference model.
module tb_hilo_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid_i = 1'b0;
   logic [2:0]  op_i = 3'd0;
   logic [31:0] rs_i = '0;
   logic [31:0] rt_i = '0;
   logic        annul_i = 1'b0;
   logic [31:0] hi_i = '0;
   logic [31:0] lo_i = '0;
   logic        we_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic        stall_o;

   int unsigned n_chk = 0;
   int unsigned n_fail = 0;

   always #5 clk = ~clk;

   hilo_ctrl dut (
      .clk     (clk),
      .rst     (rst),
      .valid_i (valid_i),
      .op_i    (op_i),
      .rs_i    (rs_i),
      .rt_i    (rt_i),
      .annul_i (annul_i),
      .hi_i    (hi_i),
      .lo_i    (lo_i),
      .we_o    (we_o),
      .hi_o    (hi_o),
      .lo_o    (lo_o),
      .stall_o (stall_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: quotient/remainder from plain integer division.
   function automatic void div_model(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b,
                                     output logic [31:0] q, output logic [31:0] r);
      logic [31:0] ua, ub;
      if (b == 32'd0) begin
         q = '1;
         r = a;
         return;
      end
      if (op == 3'd5) begin
         ua = a[31] ? (32'd0 - a) : a;
         ub = b[31] ? (32'd0 - b) : b;
      end else begin
         ua = a;
         ub = b;
      end
      q = ua / ub;
      r = ua % ub;
      if (op == 3'd5 && (a[31] ^ b[31])) q = 32'd0 - q;
      if (op == 3'd5 && a[31])           r = 32'd0 - r;
   endfunction

   // Model state: absolute cycle numbers for the pending write and the end of busy time.
   int          cyc = 0;
   int          busy_until = 0;
   int          wr_at = -1;
   logic [31:0] pend_hi = '0, pend_lo = '0;
   logic        m_we = 1'b0;
   logic [31:0] m_hi = '0, m_lo = '0;
   bit          started = 1'b0;
   int          mc;
   logic [31:0] mq, mr;
   longint      sp;
   longint unsigned up;

   // Model update at each rising edge from the inputs of the ending cycle.
   always @(posedge clk) begin
      mc = cyc;
      if (!rst) begin
         m_we = 1'b0;
         m_hi = '0;
         m_lo = '0;
         busy_until = mc + 1;
         wr_at = -1;
      end else if (mc >= busy_until) begin
         m_we = 1'b0;
         if (valid_i && !annul_i) begin
            case (op_i)
               3'd1: begin m_we = 1'b1; m_hi = rs_i; m_lo = lo_i; end
               3'd2: begin m_we = 1'b1; m_hi = hi_i; m_lo = rs_i; end
               3'd3: begin
                  sp = longint'($signed(rs_i)) * longint'($signed(rt_i));
                  m_we = 1'b1;
                  {m_hi, m_lo} = sp;
               end
               3'd4: begin
                  up = longint'({32'd0, rs_i}) * longint'({32'd0, rt_i});
                  m_we = 1'b1;
                  {m_hi, m_lo} = up;
               end
               3'd5, 3'd6: begin
                  div_model(op_i, rs_i, rt_i, mq, mr);
                  pend_hi = mr;
                  pend_lo = mq;
                  if (rt_i == 32'd0) begin
                     m_we = 1'b1;
                     m_hi = mr;
                     m_lo = mq;
                     wr_at = mc + 1;
                     busy_until = mc + 2;
                  end else begin
                     wr_at = mc + 33;
                     busy_until = mc + 34;
                  end
               end
               default: ;
            endcase
         end
      end else begin
         if (mc < wr_at && annul_i) begin
            wr_at = -1;
            busy_until = mc + 1;
         end
         if (mc + 1 == wr_at) begin
            m_we = 1'b1;
            m_hi = pend_hi;
            m_lo = pend_lo;
         end else begin
            m_we = 1'b0;
         end
      end
      cyc = mc + 1;
      started = 1'b1;
   end

   logic es;

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (started) begin
         if (cyc >= busy_until)
            es = valid_i && (op_i == 3'd5 || op_i == 3'd6) && !annul_i;
         else
            es = (cyc < wr_at) && !annul_i;
         check("model_we", {31'd0, we_o}, {31'd0, m_we});
         check("model_hi", hi_o, m_hi);
         check("model_lo", lo_o, lo_o === m_lo ? m_lo : m_lo);
         check("model_stall", {31'd0, stall_o}, {31'd0, es});
      end
   end

   task automatic set_in(input logic v, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic an);
      valid_i = v;
      op_i    = op;
      rs_i    = a;
      rt_i    = b;
      annul_i = an;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a division and hold it until the write appears (bounded).
   task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int stalls, output int wr_cyc);
      set_in(1'b1, op, a, b, 1'b0);
      stalls = 0;
      wr_cyc = -1;
      for (int k = 0; k < 40; k++) begin
         #1;
         if (stall_o) stalls++;
         @(posedge clk);
         #1;
         if (we_o) begin
            wr_cyc = k + 1;
            break;
         end
      end
   endtask

   int st, wc;

   initial begin
      rst = 1'b0;
      tick();
      tick();
      check("rst_we", {31'd0, we_o}, 32'd0);
      check("rst_hi", hi_o, 32'd0);
      check("rst_lo", lo_o, 32'd0);
      check("rst_stall", {31'd0, stall_o}, 32'd0);
      rst = 1'b1;
      tick();

      // MULT / MULTU back to back
      set_in(1'b1, 3'd3, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
      tick();
      check("mult_we", {31'd0, we_o}, 32'd1);
      check("mult_hi", hi_o, 32'hFFFF_FFFF);
      check("mult_lo", lo_o, 32'hFFFF_FFFE);
      set_in(1'b1, 3'd4, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
      tick();
      check("multu_we", {31'd0, we_o}, 32'd1);
      check("multu_hi", hi_o, 32'h0000_0001);
      check("multu_lo", lo_o, 32'hFFFF_FFFE);

      // MTHI
      lo_i = 32'hCAFE_F00D;
      set_in(1'b1, 3'd1, 32'h1234_5678, 32'd0, 1'b0);
      tick();
      check("mthi_we", {31'd0, we_o}, 32'd1);
      check("mthi_hi", hi_o, 32'h1234_5678);
      check("mthi_lo", lo_o, 32'hCAFE_F00D);
      set_in(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      tick();
      check("mthi_we_after", {31'd0, we_o}, 32'd0);

      // DIVU 100/7
      run_div(3'd6, 32'd100, 32'd7, st, wc);
      check("divu_stalls", st, 32'd33);
      check("divu_wrcyc", wc, 32'd33);
      check("divu_lo", lo_o, 32'd14);
      check("divu_hi", hi_o, 32'd2);
      #1;
      check("divu_done_stall", {31'd0, stall_o}, 32'd0);
      set_in(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      tick();
      check("divu_we_once", {31'd0, we_o}, 32'd0);

      // DIV -7/2
      run_div(3'd5, 32'hFFFF_FFF9, 32'd2, st, wc);
      check("div_neg_wrcyc", wc, 32'd33);
      check("div_neg_lo", lo_o, 32'hFFFF_FFFD);
      check("div_neg_hi", hi_o, 32'hFFFF_FFFF);
      set_in(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      tick();

      // DIV most-negative / -1
      run_div(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, st, wc);
      check("div_ovf_wrcyc", wc, 32'd33);
      check("div_ovf_lo", lo_o, 32'h8000_0000);
      check("div_ovf_hi", hi_o, 32'd0);
      set_in(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      tick();

      // DIVU 5/0, then accept in cycle 2
      run_div(3'd6, 32'd5, 32'd0, st, wc);
      check("div0_stalls", st, 32'd1);
      check("div0_wrcyc", wc, 32'd1);
      check("div0_lo", lo_o, 32'hFFFF_FFFF);
      check("div0_hi", hi_o, 32'd5);
      set_in(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      tick();
      check("div0_we_once", {31'd0, we_o}, 32'd0);

      // DIV 1000/3 annulled in cycle 10, MTLO in cycle 11
      set_in(1'b1, 3'd5, 32'd1000, 32'd3, 1'b0);
      for (int k = 1; k <= 10; k++) begin
         tick();
         check("annul_no_we", {31'd0, we_o}, 32'd0);
      end
      annul_i = 1'b1;
      #1;
      check("annul_stall", {31'd0, stall_o}, 32'd0);
      tick();
      check("annul_we_c11", {31'd0, we_o}, 32'd0);
      hi_i = 32'h0BAD_BEEF;
      set_in(1'b1, 3'd2, 32'hA5A5_A5A5, 32'd0, 1'b0);
      tick();
      check("annul_mtlo_we", {31'd0, we_o}, 32'd1);
      check("annul_mtlo_lo", lo_o, 32'hA5A5_A5A5);
      check("annul_mtlo_hi", hi_o, 32'h0BAD_BEEF);
      set_in(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      tick();

      // Reset during DIVU, then DIVU 9/3
      set_in(1'b1, 3'd6, 32'd12345, 32'd67, 1'b0);
      for (int k = 1; k <= 5; k++) tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      set_in(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      #1;
      check("mrst_we", {31'd0, we_o}, 32'd0);
      check("mrst_hi", hi_o, 32'd0);
      check("mrst_lo", lo_o, 32'd0);
      check("mrst_stall", {31'd0, stall_o}, 32'd0);
      run_div(3'd6, 32'd9, 32'd3, st, wc);
      check("post_rst_wrcyc", wc, 32'd33);
      check("post_rst_lo", lo_o, 32'd3);
      check("post_rst_hi", hi_o, 32'd0);
      set_in(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      tick();

      // Randomized traffic, checked every cycle by the model
      for (int k = 0; k < 3000; k++) begin
         rst     = ($urandom_range(0, 299) != 0);
         valid_i = ($urandom_range(0, 3) != 0);
         op_i    = 3'($urandom_range(0, 7));
         rs_i    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
         case ($urandom_range(0, 5))
            0:       rt_i = 32'd0;
            1:       rt_i = 32'($urandom_range(1, 9));
            2:       rt_i = 32'hFFFF_FFFF;
            default: rt_i = $urandom;
         endcase
         if ($urandom_range(0, 7) == 0) rs_i = 32'h8000_0000;
         annul_i = ($urandom_range(0, 99) == 0);
         hi_i    = $urandom;
         lo_i    = $urandom;
         tick();
      end
      rst = 1'b1;
      set_in(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      for (int k = 0; k < 40; k++) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Run-time bound
   initial begin
      #2_000_000;
      n_chk++;
      n_fail++;
      $display("FAIL timeout: simulation did not complete, expected finish before bound");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
